// File: rtl/v_hier_qvec_monitor.sv
// Debounces the 4-bit qvec bus and queues each committed change as {value, changed-bit mask}.
// Define V_HIER_QMON_TIMESTAMP_EN to add an 8-bit free-running timestamp to every queued event.
module v_hier_qvec_monitor #(
  parameter int DEPTH         = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       qvec,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [3:0]       evt_data,
  output logic [3:0]       evt_diff,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             overflow,
  input  logic             clr_ovf
`ifdef V_HIER_QMON_TIMESTAMP_EN
  ,
  output logic [7:0]       evt_ts
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int QW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [QW-1:0] QMAX  = QW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CFULL = CW'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_QUAL
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_q;
  logic [3:0]      r_acc;
  logic [3:0]      r_cand;
  logic [3:0]      w_cand_nxt;
  logic [QW-1:0]   r_qcnt;
  logic [QW-1:0]   w_qcnt_nxt;
  logic            w_commit;
  logic [3:0]      w_commit_val;

  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_rd;
  logic [CW-1:0]   r_count;
  logic [CNT_W-1:0] r_evt_cnt;
  logic            r_ovf;
  logic [3:0]      r_mem_data [DEPTH];
  logic [3:0]      r_mem_diff [DEPTH];

  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;

`ifdef V_HIER_QMON_TIMESTAMP_EN
  logic [7:0]      r_ts;
  logic [7:0]      r_mem_ts [DEPTH];
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cand_nxt   = r_cand;
    w_qcnt_nxt   = r_qcnt;
    w_commit     = 1'b0;
    w_commit_val = r_q;
    case (r_state)
      S_IDLE: begin
        if (r_q != r_acc) begin
          if (STABLE_CYCLES == 1) begin
            w_commit = 1'b1;
          end else begin
            w_cand_nxt  = r_q;
            w_qcnt_nxt  = QW'(1);
            w_state_nxt = S_QUAL;
          end
        end
      end
      S_QUAL: begin
        if (r_q == r_acc) begin
          w_state_nxt = S_IDLE;
        end else if (r_q != r_cand) begin
          w_cand_nxt = r_q;
          w_qcnt_nxt = QW'(1);
        end else if (r_qcnt == QMAX) begin
          w_commit     = 1'b1;
          w_commit_val = r_cand;
          w_state_nxt  = S_IDLE;
        end else begin
          w_qcnt_nxt = r_qcnt + QW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_full = (r_count == CFULL);
  assign w_pop  = evt_valid && evt_ready;
  // A full FIFO still accepts a commit when the head leaves on the same edge.
  assign w_push = w_commit && (!w_full || w_pop);
  assign w_drop = w_commit && w_full && !w_pop;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_q       <= '0;
      r_acc     <= '0;
      r_cand    <= '0;
      r_qcnt    <= '0;
      r_wr      <= '0;
      r_rd      <= '0;
      r_count   <= '0;
      r_evt_cnt <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= qvec;
      r_cand  <= w_cand_nxt;
      r_qcnt  <= w_qcnt_nxt;
      if (w_commit) begin
        r_acc     <= w_commit_val;
        r_evt_cnt <= r_evt_cnt + CNT_W'(1);
      end
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  // NOTE: storage is not reset; its contents are only observed through a nonzero count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr] <= w_commit_val;
      r_mem_diff[r_wr] <= w_commit_val ^ r_acc;
`ifdef V_HIER_QMON_TIMESTAMP_EN
      r_mem_ts[r_wr]   <= r_ts;
`endif
    end
  end

`ifdef V_HIER_QMON_TIMESTAMP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ts <= '0;
    else     r_ts <= r_ts + 8'd1;
  end

  assign evt_ts = evt_valid ? r_mem_ts[r_rd] : 8'd0;
`endif

  assign evt_valid = (r_count != '0);
  assign evt_data  = evt_valid ? r_mem_data[r_rd] : 4'd0;
  assign evt_diff  = evt_valid ? r_mem_diff[r_rd] : 4'd0;
  assign evt_cnt   = r_evt_cnt;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_v_hier_qvec_monitor.sv
// Directed bench for v_hier_qvec_monitor: debounce, glitch rejection, FIFO full/overflow, reset.
module tb_v_hier_qvec_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] qvec;
  logic       evt_valid;
  logic       evt_ready;
  logic [3:0] evt_data;
  logic [3:0] evt_diff;
  logic [7:0] evt_cnt;
  logic       overflow;
  logic       clr_ovf;
`ifdef V_HIER_QMON_TIMESTAMP_EN
  logic [7:0] evt_ts;
`endif

  int n_checks = 0;
  int n_errors = 0;

  v_hier_qvec_monitor #(.DEPTH(4), .STABLE_CYCLES(2), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .qvec      (qvec),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .evt_diff  (evt_diff),
    .evt_cnt   (evt_cnt),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
`ifdef V_HIER_QMON_TIMESTAMP_EN
    ,
    .evt_ts    (evt_ts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, ending 1 time unit after the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    qvec      = 4'h0;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  // Present v and wait until just after its commit edge.
  task automatic commit(input logic [3:0] v);
    qvec = v;
    step(3);
  endtask

  task automatic drain4(input string tag, input logic [3:0] d0, input logic [3:0] d1,
                        input logic [3:0] d2, input logic [3:0] d3,
                        input logic [3:0] f0, input logic [3:0] f1,
                        input logic [3:0] f2, input logic [3:0] f3);
    logic [3:0] ed [4];
    logic [3:0] ef [4];
    ed = '{d0, d1, d2, d3};
    ef = '{f0, f1, f2, f3};
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_valid%0d", tag, i), 32'(evt_valid), 32'd1);
      check($sformatf("%s_data%0d", tag, i), 32'(evt_data), 32'(ed[i]));
      check($sformatf("%s_diff%0d", tag, i), 32'(evt_diff), 32'(ef[i]));
      step(1);
    end
    evt_ready = 1'b0;
    check($sformatf("%s_empty", tag), 32'(evt_valid), 32'd0);
  endtask

  initial begin
    do_reset();
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_data", 32'(evt_data), 32'd0);
    check("rst_diff", 32'(evt_diff), 32'd0);
    check("rst_cnt", 32'(evt_cnt), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // Single-cycle glitch, then a 3 -> 6 double glitch; neither may commit.
    qvec = 4'h3; step(1);
    qvec = 4'h0; step(3);
    check("glitch1_valid", 32'(evt_valid), 32'd0);
    check("glitch1_cnt", 32'(evt_cnt), 32'd0);
    qvec = 4'h3; step(1);
    qvec = 4'h6; step(1);
    qvec = 4'h0; step(3);
    check("glitch2_valid", 32'(evt_valid), 32'd0);
    check("glitch2_cnt", 32'(evt_cnt), 32'd0);

    // Basic commit and its latency.
    qvec = 4'h5; step(2);
    check("lat_not_yet", 32'(evt_valid), 32'd0);
    step(1);
    check("c5_valid", 32'(evt_valid), 32'd1);
    check("c5_data", 32'(evt_data), 32'h5);
    check("c5_diff", 32'(evt_diff), 32'h5);
    check("c5_cnt", 32'(evt_cnt), 32'd1);
    step(2);
    check("c5_hold_cnt", 32'(evt_cnt), 32'd1);
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;
    check("c5_popped", 32'(evt_valid), 32'd0);
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;
    check("pop_empty_noop", 32'(evt_valid), 32'd0);

    // Overflow: five commits into a 4-deep FIFO with no consumer.
    do_reset();
    commit(4'h1); commit(4'h2); commit(4'h3); commit(4'h4);
    check("fill_ovf", 32'(overflow), 32'd0);
    commit(4'h5);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_cnt", 32'(evt_cnt), 32'd5);
    drain4("ovf", 4'h1, 4'h2, 4'h3, 4'h4, 4'h1, 4'h3, 4'h1, 4'h7);
    check("ovf_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1; step(1); clr_ovf = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO with pop on the commit edge; acc is 5 from the dropped commit.
    commit(4'h6); commit(4'h7); commit(4'h8); commit(4'h9);
    qvec = 4'hA; step(2);
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;
    check("fullpop_ovf", 32'(overflow), 32'd0);
    check("fullpop_cnt", 32'(evt_cnt), 32'd10);
    drain4("fullpop", 4'h7, 4'h8, 4'h9, 4'hA, 4'h1, 4'hF, 4'h1, 4'h3);

    // Reset while qualifying with two events queued.
    commit(4'hB); commit(4'hC);
    qvec = 4'hD; step(2);
    rst = 1'b1; qvec = 4'hA; #1;
    check("arst_valid", 32'(evt_valid), 32'd0);
    check("arst_data", 32'(evt_data), 32'd0);
    check("arst_cnt", 32'(evt_cnt), 32'd0);
    step(2);
    rst = 1'b0;
    step(2);
    check("post_rst_lat", 32'(evt_valid), 32'd0);
    step(1);
    check("post_rst_valid", 32'(evt_valid), 32'd1);
    check("post_rst_data", 32'(evt_data), 32'hA);
    check("post_rst_diff", 32'(evt_diff), 32'hA);
    check("post_rst_cnt", 32'(evt_cnt), 32'd1);

`ifdef V_HIER_QMON_TIMESTAMP_EN
    // Commits land on the 4th and 10th edges after release: stamps 3 and 9.
    do_reset();
    step(1);
    commit(4'h1);
    step(3);
    commit(4'h2);
    check("ts_first", 32'(evt_ts), 32'd3);
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;
    check("ts_second", 32'(evt_ts), 32'd9);
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;
    check("ts_empty", 32'(evt_ts), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/v_hier_qvec_monitor.md
Name: v_hier_qvec_monitor

Overview:
- Downstream consumer of the 4-bit qvec bus driven by the v_hier_sub stage.
- Registers qvec and debounces it: a new value is committed only after it has been held for STABLE_CYCLES samples.
- Each committed change is pushed into a small FIFO as an event {new value, changed-bit mask}, drained through a valid/ready port.
- Keeps a wrapping commit counter and a sticky overflow flag for the testbench scoreboard.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2).
- STABLE_CYCLES, 2, consecutive identical samples required to commit (>=1).
- CNT_W, 8, width of evt_cnt.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- qvec  input  4  monitored bus from v_hier_sub.
- evt_valid  output  1  FIFO head valid.
- evt_ready  input  1  consumer accepts head.
- evt_data  output  4  committed qvec value at head.
- evt_diff  output  4  bits changed versus previous committed value.
- evt_cnt  output  CNT_W  number of commits since reset, wraps.
- overflow  output  1  sticky: a commit was dropped because the FIFO was full.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset: all state clears asynchronously. This covers q_r, acc (committed value), cand, the qualification counter, the FIFO pointers and count, evt_cnt and overflow. Outputs read evt_valid=0, evt_data=0, evt_diff=0, evt_cnt=0, overflow=0. FSM returns to IDLE. Reset mid-qualification or with a non-empty FIFO discards everything.
- q_r <= qvec every edge. The FSM compares q_r, i.e. the qvec from the previous edge.
- FSM IDLE, when q_r != acc:
  - If STABLE_CYCLES==1, commit q_r immediately.
  - Otherwise cand<=q_r, qcnt<=1, go to QUAL.
- FSM IDLE, when q_r == acc: stay.
- FSM QUAL:
  - q_r==acc: abort to IDLE, no event.
  - q_r!=cand and q_r!=acc: restart with cand<=q_r, qcnt<=1.
  - q_r==cand and qcnt==STABLE_CYCLES-1: commit cand, go to IDLE.
  - q_r==cand otherwise: qcnt++.
- Commit (single edge):
  - acc<=value.
  - Push {value, value^acc_old}.
  - evt_cnt++ modulo 2^CNT_W. This happens even if the push is dropped.
- Latency: qvec changes before edge 0 and is held through edge STABLE_CYCLES-1. Commit occurs at edge STABLE_CYCLES. If the FIFO was empty, evt_valid is high immediately after that edge. With defaults, that is 2 clocks after first sampling.
- FIFO is show-ahead: evt_data/evt_diff are registered head contents, valid whenever count>0. Pop occurs on evt_valid && evt_ready.
- Boundary cases:
  - Full, no pop, commit: event dropped, acc still updated, overflow<=1.
  - Full with simultaneous pop and commit: both happen, count unchanged, no overflow.
  - Empty with commit: push only. evt_ready while empty has no effect.
  - Pointers wrap modulo DEPTH.
- clr_ovf clears overflow next edge. A new overflow in the same cycle wins (overflow stays 1).
- qvec nonzero coming out of reset produces a first event with evt_diff = that value (acc resets to 0).

Optional Feature:
- Macro V_HIER_QMON_TIMESTAMP_EN.
- When defined:
  - An 8-bit free-running counter ts (reset 0, wraps) is added.
  - Each FIFO entry also stores ts at the commit edge.
  - Extra output port evt_ts [7:0] presents the head timestamp (0 when empty).
- When undefined: the evt_ts port, the counter and the storage are absent. All other behaviour is identical.

Test Plan:
- Reset; qvec 0->4'h5 held 3 cycles -> evt_valid rises 2 clocks after first sample, evt_data=5, evt_diff=5, evt_cnt=1.
- Glitch: qvec 0->4'h3 for 1 cycle then back to 0 -> no event, evt_cnt=0; a second glitch 0->3->6, each held 1 cycle -> no event.
- Hold evt_ready=0; commit 5 distinct values 1,2,3,4,5 -> FIFO holds 1..4, overflow=1, evt_cnt=5. Drain reads diffs 1,3,1,7. Pulse clr_ovf -> overflow=0.
- FIFO full, evt_ready=1 on the same edge as a commit -> no overflow, count stays 4, order preserved.
- Assert rst while in QUAL with 2 queued events -> all outputs 0 after the reset edge. With qvec=4'hA held after release -> event data=A, diff=A.
- With V_HIER_QMON_TIMESTAMP_EN: commits at ts=3 and ts=9 -> evt_ts reads 3 then 9. With ts wrapping past 255, the stamp equals the commit cycle modulo 256.
